seg7_scan_ctrl: RTL and testbench

- Time-multiplexing scan controller for the board's 4-digit common-anode seven-segment display.
- Cycles one active-low anode at a time and drives the matching digit's active-low segment pattern and decimal point.
- Inserts an all-off guard interval between digits to suppress ghosting.
- Takes new display contents through a Load/Ready handshake, double-buffered so updates land only on frame boundaries. Sits between counter/datapath blocks and the display pins.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 25 ++
 rtl/seg7_scan_ctrl.sv | 116 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;
    localparam int NDIG = 4;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_TWO   = 7'b0100100;
    localparam logic [6:0] SEG_THREE = 7'b0110000;
    localparam logic [6:0] SEG_FOUR  = 7'b0011001;
    localparam logic [6:0] SEG_FIVE  = 7'b0010010;
    localparam logic [6:0] SEG_SIX   = 7'b0000010;
    localparam logic [6:0] SEG_SEVEN = 7'b1111000;
    localparam logic [6:0] SEG_EIGHT = 7'b0000000;
    localparam logic [6:0] SEG_NINE  = 7'b0010000;
    localparam logic [6:0] DASH      = 7'b0111111;
    localparam logic [6:0] BLANK     = 7'b1111111;

    typedef enum logic {PH_ON, PH_GUARD} phase_e;
endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low segment pattern.
// Non-decimal nibbles render as a dash so bad data is visible on the display.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = DASH;
        case (i_nib)
            4'd0: o_seg = SEG_ZERO;
            4'd1: o_seg = SEG_ONE;
            4'd2: o_seg = SEG_TWO;
            4'd3: o_seg = SEG_THREE;
            4'd4: o_seg = SEG_FOUR;
            4'd5: o_seg = SEG_FIVE;
            4'd6: o_seg = SEG_SIX;
            4'd7: o_seg = SEG_SEVEN;
            4'd8: o_seg = SEG_EIGHT;
            4'd9: o_seg = SEG_NINE;
            default: o_seg = DASH;
        endcase
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller with per-slot guard interval and
// double-buffered Load/Ready update that only lands on frame boundaries.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter int GUARD    = 1_000,
    parameter int CNT_BITS = 17
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Load,
    output logic        Ready,
    input  logic [15:0] Digits_in,
    input  logic [3:0]  Blank_in,
    input  logic [3:0]  Dp_in,
    input  logic        Lz_en,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic [3:0]  an
);
    localparam logic [CNT_BITS-1:0] CNT_LAST    = CNT_BITS'(SCAN_DIV - 1);
    localparam logic [CNT_BITS-1:0] GUARD_START = CNT_BITS'(SCAN_DIV - GUARD);

    logic [CNT_BITS-1:0] r_cnt;
    logic [1:0]          r_idx;
    logic                r_pending;
    logic [15:0]         r_act_dig, r_stg_dig;
    logic [3:0]          r_act_blank, r_stg_blank;
    logic [3:0]          r_act_dp, r_stg_dp;

    phase_e                  w_phase;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_accept;
    logic [NDIG-1:0][3:0]    w_digs;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg;
    logic [NDIG-1:0]         w_lz_dark;
    logic                    w_zero_above;
    logic                    w_dark;

    assign w_phase     = (r_cnt < GUARD_START) ? PH_ON : PH_GUARD;
    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);
    assign w_accept    = Load && Ready;
    assign w_digs      = r_act_dig;
    assign w_nib       = w_digs[r_idx];

    // A digit is zero-suppressed when it and every digit to its left are zero.
    always_comb begin
        w_zero_above = 1'b1;
        w_lz_dark    = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (w_digs[i] == 4'd0);
            w_lz_dark[i] = Lz_en && (i >= 1) && w_zero_above;
        end
    end

    assign w_dark = r_act_blank[r_idx] || w_lz_dark[r_idx];

    seg7_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            r_act_dig   <= '0;
            r_act_blank <= '0;
            r_act_dp    <= '0;
            r_stg_dig   <= '0;
            r_stg_blank <= '0;
            r_stg_dp    <= '0;
            Ready       <= 1'b1;
            an          <= 4'b1111;
            Seg         <= BLANK;
            Dp          <= 1'b1;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_BITS'(1);
            end

            // Accept is impossible while pending, so these never collide.
            if (w_frame_end && r_pending) begin
                r_act_dig   <= r_stg_dig;
                r_act_blank <= r_stg_blank;
                r_act_dp    <= r_stg_dp;
                r_pending   <= 1'b0;
                Ready       <= 1'b1;
            end else if (w_accept) begin
                r_stg_dig   <= Digits_in;
                r_stg_blank <= Blank_in;
                r_stg_dp    <= Dp_in;
                r_pending   <= 1'b1;
                Ready       <= 1'b0;
            end

            if (w_phase == PH_ON) begin
                an  <= ~(4'b0001 << r_idx);
                Seg <= w_dark ? BLANK : w_seg;
                Dp  <= w_dark ? 1'b1 : ~r_act_dp[r_idx];
            end else begin
                an  <= 4'b1111;
                Seg <= BLANK;
                Dp  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: cycle-indexed behavioural model of the scan display,
// directed scenarios with literal pins, then randomized traffic.
module tb_seg7_scan_ctrl;
    localparam int SD = 8;
    localparam int G  = 2;
    localparam int FR = 4 * SD;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic        Load = 1'b0;
    logic        Lz_en = 1'b0;
    logic [15:0] Digits_in = '0;
    logic [3:0]  Blank_in = '0;
    logic [3:0]  Dp_in = '0;
    logic        Ready;
    logic [6:0]  Seg;
    logic        Dp;
    logic [3:0]  an;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .GUARD(G), .CNT_BITS(3)) dut (
        .Clk(Clk), .Clr(Clr), .Load(Load), .Ready(Ready),
        .Digits_in(Digits_in), .Blank_in(Blank_in), .Dp_in(Dp_in),
        .Lz_en(Lz_en), .Seg(Seg), .Dp(Dp), .an(an)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mk is the index (within a frame) of the next clock edge.
    int          mk = 0;
    int          m_pos, m_d;
    bit          m_valid = 1'b0;
    bit          m_pend, m_dark, m_allz;
    logic [15:0] m_dig, s_dig;
    logic [3:0]  m_blank, m_dp, s_blank, s_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ready;

    function automatic logic [6:0] pat(input logic [3:0] n);
        logic [6:0] tbl [0:9];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (n > 4'd9) ? 7'b0111111 : tbl[n];
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(posedge Clk) begin
        if (Clr) begin
            mk = 0; m_pend = 0; m_valid = 1;
            m_dig = '0; m_blank = '0; m_dp = '0;
            s_dig = '0; s_blank = '0; s_dp = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1; e_ready = 1;
        end else if (m_valid) begin
            m_pos = mk % SD;
            m_d   = mk / SD;
            if (m_pos < SD - G) begin
                e_an = 4'hF;
                e_an[m_d] = 1'b0;
                m_allz = 1;
                for (int j = m_d; j < 4; j++)
                    if (m_dig[4*j +: 4] != 4'd0) m_allz = 0;
                m_dark = m_blank[m_d] || (Lz_en && m_d >= 1 && m_allz);
                e_seg = m_dark ? 7'h7F : pat(m_dig[4*m_d +: 4]);
                e_dp  = m_dark ? 1'b1 : !m_dp[m_d];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1;
            end
            if (mk == FR - 1 && m_pend) begin
                m_dig = s_dig; m_blank = s_blank; m_dp = s_dp; m_pend = 0;
            end else if (Load && !m_pend) begin
                s_dig = Digits_in; s_blank = Blank_in; s_dp = Dp_in; m_pend = 1;
            end
            e_ready = !m_pend;
            mk = (mk + 1) % FR;
        end
    end

    always @(negedge Clk)
        if (m_valid)
            chk("outputs{an,Seg,Dp,Ready}", {3'b0, an, Seg, Dp, Ready},
                {3'b0, e_an, e_seg, e_dp, e_ready});

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic wait_phase(input int target);
        int n = 0;
        while (mk != target && n < 4 * FR) begin
            tick();
            n++;
        end
        if (mk != target) begin
            n_tests++; n_fail++;
            $display("FAIL wait_phase: reached %0d expected %0d", mk, target);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        int n = 0;
        while (!Ready && n < 4 * FR) begin
            tick();
            n++;
        end
        if (!Ready) begin
            n_tests++; n_fail++;
            $display("FAIL do_load: Ready stuck low got %b expected 1", Ready);
        end
        Load = 1; Digits_in = d; Blank_in = b; Dp_in = p;
        tick();
        Load = 0;
    endtask

    initial begin
        logic [15:0] v;
        @(negedge Clk);
        tick(); tick();
        chk("rst_an", an, 4'hF);
        chk("rst_seg", Seg, 7'h7F);
        chk("rst_dp", Dp, 1'b1);
        chk("rst_ready", Ready, 1'b1);
        Clr = 0;

        // Load at cycle 0 of frame 0; shows in frame 1.
        Load = 1; Digits_in = 16'h1234;
        tick();
        Load = 0;
        chk("ready_low_after_load", Ready, 1'b0);
        repeat (30) tick();
        chk("ready_low_k30", Ready, 1'b0);
        tick();
        chk("ready_high_k31", Ready, 1'b1);
        chk("guard_an_k31", an, 4'hF);
        tick();
        chk("f1_d0_an", an, 4'b1110);
        chk("f1_d0_seg_four", Seg, 7'b0011001);
        repeat (8) tick();
        chk("f1_d1_an", an, 4'b1101);
        chk("f1_d1_seg_three", Seg, 7'b0110000);

        // Leading-zero suppression.
        Lz_en = 1;
        do_load(16'h0070, 4'b0000, 4'b0000);
        repeat (2 * FR) tick();
        wait_phase(9); tick();
        chk("lz_d1_an", an, 4'b1101);
        chk("lz_d1_seven", Seg, 7'b1111000);
        wait_phase(25); tick();
        chk("lz_d3_an", an, 4'b0111);
        chk("lz_d3_dark", Seg, 7'h7F);
        do_load(16'h0000, 4'b0000, 4'b0000);
        repeat (2 * FR) tick();
        wait_phase(17); tick();
        chk("lz0_d2_an", an, 4'b1011);
        chk("lz0_d2_dark", Seg, 7'h7F);
        wait_phase(1); tick();
        chk("lz0_d0_zero", Seg, 7'b1000000);

        // Load on the boundary cycle, then an ignored 9999.
        Lz_en = 0;
        wait_phase(FR - 1);
        Load = 1; Digits_in = 16'h4321;
        tick();
        Digits_in = 16'h9999;
        tick();
        Load = 0;
        tick();
        chk("bnd_next_frame_old", Seg, 7'b1000000);
        wait_phase(0); tick();
        chk("bnd_frame_after_an", an, 4'b1110);
        chk("bnd_frame_after_one", Seg, 7'b1111001);

        // Dash, force-blank and decimal point.
        do_load(16'hFA05, 4'b0010, 4'b0001);
        repeat (2 * FR) tick();
        wait_phase(1); tick();
        chk("fa05_d0_five_dp", {Seg, Dp}, {7'b0010010, 1'b0});
        wait_phase(9); tick();
        chk("fa05_d1_dark", {an, Seg, Dp}, {4'b1101, 7'h7F, 1'b1});
        wait_phase(25); tick();
        chk("fa05_d3_dash", Seg, 7'b0111111);

        // Clear in the guard of digit 2 with a pending update.
        wait_phase(0);
        do_load(16'h8888, 4'b0000, 4'b1111);
        wait_phase(2 * SD + SD - G);
        Clr = 1;
        tick();
        Clr = 0;
        chk("clr_an", an, 4'hF);
        chk("clr_seg", Seg, 7'h7F);
        chk("clr_ready", Ready, 1'b1);
        tick();
        chk("clr_restart_d0", {an, Seg, Dp}, {4'b1110, 7'b1000000, 1'b1});
        repeat (2 * FR) tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            Clr  = ($urandom_range(0, 599) == 0);
            Load = ($urandom_range(0, 5) == 0);
            for (int j = 0; j < 4; j++)
                v[4*j +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
            Digits_in = v;
            Blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            Dp_in     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) Lz_en = ~Lz_en;
            tick();
        end
        Clr = 0; Load = 0;
        repeat (FR) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
